// File: rtl/rgb565_pixel_unpacker.sv
// Unpacks 32-bit words of two RGB565 pixels into a stream of RGB888 pixels with frame position markers.
// Define RGB565_ZERO_FILL_EN to zero-fill the expanded LSBs instead of replicating the MSBs.
module rgb565_pixel_unpacker #(
  parameter int LINE_PIXELS = 640,
  parameter int FRAME_LINES = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_red,
  output logic [7:0]  out_green,
  output logic [7:0]  out_blue,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eol,
  output logic        underflow
);

  localparam int XW = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int YW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(LINE_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_LINES - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOW   = 2'd1,
    S_HIGH  = 2'd2
  } state_t;

  state_t          state_p0;
  state_t          state_nxt;
  logic [31:0]     word_p0;
  logic [XW-1:0]   x_p0;
  logic [YW-1:0]   y_p0;
  logic            underflow_p0;
  logic            sel_high;
  logic            in_xfer;
  logic            out_xfer;
  logic            at_origin;
  logic            starve;
  logic [15:0]     pix;

  function automatic logic [7:0] expand5(input logic [4:0] c);
`ifdef RGB565_ZERO_FILL_EN
    return {c, 3'b000};
`else
    return {c, c[4:2]};
`endif
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] c);
`ifdef RGB565_ZERO_FILL_EN
    return {c, 2'b00};
`else
    return {c, c[5:4]};
`endif
  endfunction

  // Stage p0: word register and sequencer state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p0 <= S_EMPTY;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p0;
    unique case (state_p0)
      S_EMPTY: if (in_valid) state_nxt = S_LOW;
      S_LOW:   if (out_ready) state_nxt = S_HIGH;
      S_HIGH:  if (out_ready) state_nxt = in_valid ? S_LOW : S_EMPTY;
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b0;
    sel_high  = 1'b0;
    unique case (state_p0)
      S_EMPTY: in_ready = 1'b1;
      S_LOW:   out_valid = 1'b1;
      S_HIGH: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        sel_high  = 1'b1;
      end
      default: in_ready = 1'b1;
    endcase
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // A word only loads in EMPTY or when its second pixel is leaving, so it is never clobbered early
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_p0 <= '0;
    end else if (in_xfer) begin
      word_p0 <= in_data;
    end
  end

  // Frame position of the pixel currently presented
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_p0 <= '0;
      y_p0 <= '0;
    end else if (out_xfer) begin
      if (x_p0 == X_LAST) begin
        x_p0 <= '0;
        y_p0 <= (y_p0 == Y_LAST) ? '0 : y_p0 + YW'(1);
      end else begin
        x_p0 <= x_p0 + XW'(1);
      end
    end
  end

  assign at_origin = (x_p0 == '0) && (y_p0 == '0);
  assign starve    = out_ready && !out_valid && !at_origin;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow_p0 <= 1'b0;
    end else if (starve) begin
      underflow_p0 <= 1'b1;
    end else if (out_xfer && at_origin) begin
      underflow_p0 <= 1'b0;
    end
  end

  // Stage p0 output: half-word select and colour expansion
  assign pix       = !out_valid ? 16'h0000 : (sel_high ? word_p0[31:16] : word_p0[15:0]);
  assign out_red   = expand5(pix[15:11]);
  assign out_green = expand6(pix[10:5]);
  assign out_blue  = expand5(pix[4:0]);
  assign out_sof   = out_valid && at_origin;
  assign out_eol   = out_valid && (x_p0 == X_LAST);
  assign underflow = underflow_p0;

endmodule

// File: tb/tb_rgb565_pixel_unpacker.sv
// Scoreboard bench for rgb565_pixel_unpacker: expected pixels queued on word acceptance, checked by a monitor.
module tb_rgb565_pixel_unpacker;

  localparam int LP = 4;
  localparam int FL = 2;

  logic        clk;
  logic        reset_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_red;
  logic [7:0]  out_green;
  logic [7:0]  out_blue;
  logic        out_valid;
  logic        out_ready;
  logic        out_sof;
  logic        out_eol;
  logic        underflow;

  int total = 0;
  int bad   = 0;

  logic [23:0] exp_q[$];
  int          pix_idx  = 0;
  int          mon_pos  = 0;
  logic        model_uf = 1'b0;
  logic        stall_prev = 1'b0;
  logic [25:0] held = '0;
  logic [23:0] exp_px;

`ifdef RGB565_ZERO_FILL_EN
  localparam logic [23:0] A0 = 24'h00FC00;
  localparam logic [23:0] A1 = 24'hF80000;
  localparam logic [23:0] B0 = 24'h808080;
  localparam logic [23:0] B1 = 24'h0000F8;
`else
  localparam logic [23:0] A0 = 24'h00FF00;
  localparam logic [23:0] A1 = 24'hFF0000;
  localparam logic [23:0] B0 = 24'h848284;
  localparam logic [23:0] B1 = 24'h0000FF;
`endif

  rgb565_pixel_unpacker #(
    .LINE_PIXELS(LP),
    .FRAME_LINES(FL)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_red  (out_red),
    .out_green(out_green),
    .out_blue (out_blue),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sof  (out_sof),
    .out_eol  (out_eol),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] ref_pixel(input logic [15:0] p);
    int v, r, g, b, r8, g8, b8;
    logic [23:0] res;
    v = int'(p);
    r = v / 2048;
    g = (v / 32) % 64;
    b = v % 32;
`ifdef RGB565_ZERO_FILL_EN
    r8 = r * 8;
    g8 = g * 4;
    b8 = b * 8;
`else
    r8 = r * 8 + r / 4;
    g8 = g * 4 + g / 16;
    b8 = b * 8 + b / 4;
`endif
    res = (r8 * 65536) + (g8 * 256) + b8;
    return res;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Stimulus side of the scoreboard: every accepted word queues its two pixels in display order
  always @(negedge clk) begin
    if (reset_n && in_valid && in_ready) begin
      exp_q.push_back(ref_pixel(in_data[15:0]));
      exp_q.push_back(ref_pixel(in_data[31:16]));
    end
  end

  // Monitor: pops on each output transfer, tracks frame position and sticky starvation flag
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      pix_idx    = 0;
      model_uf   = 1'b0;
      stall_prev = 1'b0;
    end else begin
      chk("underflow", {31'd0, underflow}, {31'd0, model_uf});
      if (stall_prev) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", {6'd0, out_red, out_green, out_blue, out_sof, out_eol}, {6'd0, held});
      end
      if (out_valid && !out_ready)
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      mon_pos = pix_idx % (LP * FL);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_pixel", 32'd1, 32'd0);
        end else begin
          exp_px = exp_q.pop_front();
          chk("sb_rgb", {8'd0, out_red, out_green, out_blue}, {8'd0, exp_px});
        end
        chk("sb_sof", {31'd0, out_sof}, {31'd0, (mon_pos == 0)});
        chk("sb_eol", {31'd0, out_eol}, {31'd0, ((mon_pos % LP) == LP - 1)});
        if (mon_pos == 0) model_uf = 1'b0;
        pix_idx++;
      end else if (out_ready && !out_valid && mon_pos != 0) begin
        model_uf = 1'b1;
      end
      stall_prev = out_valid && !out_ready;
      held = {out_red, out_green, out_blue, out_sof, out_eol};
    end
  end

  task automatic send_word(input logic [31:0] w);
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_data = w;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic check_px(input string nm, input logic [23:0] px, input logic sof);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_rgb"}, {8'd0, out_red, out_green, out_blue}, {8'd0, px});
      chk({nm, "_sof"}, {31'd0, out_sof}, {31'd0, sof});
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({nm, "_rgb"}, {8'd0, out_red, out_green, out_blue}, 32'd0);
    chk({nm, "_sof"}, {31'd0, out_sof}, 32'd0);
    chk({nm, "_eol"}, {31'd0, out_eol}, 32'd0);
    chk({nm, "_underflow"}, {31'd0, underflow}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #2 check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;

    // Directed words: colour expansion, first-pixel marker and latency
    send_word(32'hF800_07E0);
    check_px("w0_p0", A0, 1'b1);
    chk("w0_p0_in_ready", {31'd0, in_ready}, 32'd0);
    check_px("w0_p1", A1, 1'b0);
    send_word(32'h001F_8410);
    check_px("w1_p0", B0, 1'b0);
    check_px("w1_p1", B1, 1'b0);

    // Continuous stream: one pixel per cycle
    do_reset();
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b1;
    in_data = $urandom;
    @(posedge clk);
    #1 in_data = $urandom;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("no_bubble", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1 in_data = $urandom;
    end
    in_valid = 1'b0;

    // Mid-line starvation sets underflow until the next frame origin transfers
    do_reset();
    out_ready = 1'b1;
    send_word($urandom);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("underflow_set", {31'd0, underflow}, 32'd1);
    in_valid = 1'b1;
    in_data = $urandom;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_sof) begin
        found = 1'b1;
        break;
      end
    end
    chk("sof_reached", {31'd0, found}, 32'd1);
    @(negedge clk);
    chk("underflow_clear", {31'd0, underflow}, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;

    // Asynchronous reset while a word is held in LOW mid-line
    do_reset();
    out_ready = 1'b1;
    send_word($urandom);
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    send_word($urandom);
    @(negedge clk);
    chk("low_held_valid", {31'd0, out_valid}, 32'd1);
    chk("low_held_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    send_word(32'hF800_07E0);
    check_px("post_rst_p0", A0, 1'b1);

    // Random traffic with back-pressure
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1 in_valid = ($urandom % 10) < 7;
      in_data = $urandom;
      out_ready = ($urandom % 10) < 6;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
